instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 198 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder streaming words into instruction memory
// Optional LI (LUI+ORI) expansion is enabled by defining ENC_PSEUDO_EN.
module instr_encoder #(
    parameter int IM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_kind,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_imm,
    input  logic             base_load,
    input  logic [IM_AW-1:0] base_addr,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             full,
    output logic             err,
    output logic [IM_AW:0]   wr_count
);

    localparam logic [1:0] ST_RUN  = 2'd0;
`ifdef ENC_PSEUDO_EN
    localparam logic [1:0] ST_LI2  = 2'd1;
`endif
    localparam logic [1:0] ST_FULL = 2'd2;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] func);
        return {6'h00, rs, rt, rd, sh, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IM_AW-1:0] ptr_q, ptr_d;
    logic [IM_AW:0]   cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [IM_AW-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [31:0]      word0;
    logic             kind_ok;
    logic             is_li;
    logic             ptr_last;
    logic             accept;
`ifdef ENC_PSEUDO_EN
    logic [31:0]      li_lo_q, li_lo_d;
`else
    logic             unused_imm;
    assign unused_imm = ^in_imm[31:26];
`endif

    assign in_ready = ~rst & ~base_load & (state_q == ST_RUN);
    assign accept   = in_valid & in_ready;
    assign ptr_last = (ptr_q == {IM_AW{1'b1}});

    always_comb begin
        word0   = '0;
        kind_ok = 1'b1;
        is_li   = 1'b0;
        case (in_kind)
            6'd0:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
            6'd1:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
            6'd2:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
            6'd3:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
            6'd4:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
            6'd5:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
            6'd6:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
            6'd7:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
            6'd8:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h04);
            6'd9:  word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h07);
            6'd10: word0 = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h06);
            // Immediate shifts carry the amount in shamt, so rs is unused.
            6'd11: word0 = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
            6'd12: word0 = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
            6'd13: word0 = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h03);
            6'd14: word0 = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
            6'd15: word0 = r_word(in_rs, 5'd0, in_rd, 5'd0, 6'h09);
            6'd16: word0 = i_word(6'h09, in_rs, in_rt, in_imm[15:0]);
            6'd17: word0 = i_word(6'h0F, 5'd0, in_rt, in_imm[15:0]);
            6'd18: word0 = i_word(6'h0A, in_rs, in_rt, in_imm[15:0]);
            6'd19: word0 = i_word(6'h0B, in_rs, in_rt, in_imm[15:0]);
            6'd20: word0 = i_word(6'h0C, in_rs, in_rt, in_imm[15:0]);
            6'd21: word0 = i_word(6'h0D, in_rs, in_rt, in_imm[15:0]);
            6'd22: word0 = i_word(6'h0E, in_rs, in_rt, in_imm[15:0]);
            6'd23: word0 = i_word(6'h04, in_rs, in_rt, in_imm[15:0]);
            6'd24: word0 = i_word(6'h05, in_rs, in_rt, in_imm[15:0]);
            6'd25: word0 = i_word(6'h01, in_rs, 5'd1, in_imm[15:0]);
            6'd26: word0 = i_word(6'h07, in_rs, 5'd0, in_imm[15:0]);
            6'd27: word0 = i_word(6'h06, in_rs, 5'd0, in_imm[15:0]);
            6'd28: word0 = i_word(6'h01, in_rs, 5'd0, in_imm[15:0]);
            6'd29: word0 = i_word(6'h23, in_rs, in_rt, in_imm[15:0]);
            6'd30: word0 = i_word(6'h2B, in_rs, in_rt, in_imm[15:0]);
            6'd31: word0 = i_word(6'h20, in_rs, in_rt, in_imm[15:0]);
            6'd32: word0 = i_word(6'h24, in_rs, in_rt, in_imm[15:0]);
            6'd33: word0 = i_word(6'h28, in_rs, in_rt, in_imm[15:0]);
            6'd34: word0 = {6'h02, in_imm[25:0]};
            6'd35: word0 = {6'h03, in_imm[25:0]};
`ifdef ENC_PSEUDO_EN
            6'd36: begin
                word0 = i_word(6'h0F, 5'd0, in_rt, in_imm[31:16]);
                is_li = 1'b1;
            end
`endif
            default: kind_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
`ifdef ENC_PSEUDO_EN
        li_lo_d = li_lo_q;
`endif
        if (base_load) begin
            ptr_d   = base_addr;
            cnt_d   = '0;
            state_d = ST_RUN;
`ifdef ENC_PSEUDO_EN
        end else if (state_q == ST_LI2) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = li_lo_q;
            cnt_d   = cnt_q + 1'b1;
            ptr_d   = ptr_last ? ptr_q : ptr_q + 1'b1;
            state_d = ptr_last ? ST_FULL : ST_RUN;
`endif
        end else if (accept) begin
            // LI needs two free words; with only the last word left it is refused whole.
            if (!kind_ok || (is_li && ptr_last)) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = word0;
                cnt_d   = cnt_q + 1'b1;
                ptr_d   = ptr_last ? ptr_q : ptr_q + 1'b1;
                if (ptr_last) begin
                    state_d = ST_FULL;
                end
`ifdef ENC_PSEUDO_EN
                if (is_li) begin
                    state_d = ST_LI2;
                    li_lo_d = i_word(6'h0D, in_rt, in_rt, in_imm[15:0]);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef ENC_PSEUDO_EN
            li_lo_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef ENC_PSEUDO_EN
            li_lo_q <= li_lo_d;
`endif
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign err      = err_q;
    assign wr_count = cnt_q;
    assign full     = (state_q == ST_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder (IM_AW=10 and IM_AW=2 instances)
module tb_instr_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, base_load;
    logic [5:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm;
    logic [9:0]  base_addr;

    logic        rdy0, we0, full0, err0;
    logic [9:0]  addr0;
    logic [31:0] data0;
    logic [10:0] cnt0;
    logic        rdy1, we1, full1, err1;
    logic [1:0]  addr1;
    logic [31:0] data1;
    logic [2:0]  cnt1;

    instr_encoder #(.IM_AW(10)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .base_load(base_load), .base_addr(base_addr), .im_we(we0), .im_addr(addr0),
        .im_wdata(data0), .full(full0), .err(err0), .wr_count(cnt0));

    instr_encoder #(.IM_AW(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .base_load(base_load), .base_addr(base_addr[1:0]), .im_we(we1), .im_addr(addr1),
        .im_wdata(data1), .full(full1), .err(err1), .wr_count(cnt1));

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference tables: words produced per kind from the mnemonic definitions.
    bit [5:0] rfunc [16] = '{6'h21, 6'h23, 6'h2A, 6'h24, 6'h27, 6'h25, 6'h26, 6'h2B,
                             6'h04, 6'h07, 6'h06, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
    bit [5:0] iop [7]    = '{6'h09, 6'h0F, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    bit [5:0] bop [6]    = '{6'h04, 6'h05, 6'h01, 6'h07, 6'h06, 6'h01};
    bit [5:0] mop [5]    = '{6'h23, 6'h2B, 6'h20, 6'h24, 6'h28};

    function automatic bit [31:0] fields(bit [5:0] op, bit [4:0] a, bit [4:0] b, bit [15:0] lo);
        return (32'(op) << 26) + (32'(a) << 21) + (32'(b) << 16) + 32'(lo);
    endfunction

    function automatic void encode(input int k, input bit [4:0] rs, input bit [4:0] rt,
                                   input bit [4:0] rd, input bit [4:0] sh, input bit [31:0] imm,
                                   output int n, output bit [31:0] w0, output bit [31:0] w1);
        bit [4:0] a, b, d, s;
        n = 1; w0 = 0; w1 = 0;
        if (k < 16) begin
            a = (k >= 11 && k <= 13) ? 5'd0 : rs;
            b = (k >= 14) ? 5'd0 : rt;
            d = (k == 14) ? 5'd0 : rd;
            s = (k >= 11 && k <= 13) ? sh : 5'd0;
            w0 = fields(6'h00, a, b, {d, s, rfunc[k]});
        end else if (k < 23) begin
            w0 = fields(iop[k-16], (k == 17) ? 5'd0 : rs, rt, imm[15:0]);
        end else if (k < 29) begin
            b = (k == 25) ? 5'd1 : (k >= 26) ? 5'd0 : rt;
            w0 = fields(bop[k-23], rs, b, imm[15:0]);
        end else if (k < 34) begin
            w0 = fields(mop[k-29], rs, rt, imm[15:0]);
        end else if (k < 36) begin
            w0 = (32'(k - 32) << 26) + (imm & 32'h03FF_FFFF);
`ifdef ENC_PSEUDO_EN
        end else if (k == 36) begin
            n = 2;
            w0 = fields(6'h0F, 5'd0, rt, imm[31:16]);
            w1 = fields(6'h0D, rt, rt, imm[15:0]);
`endif
        end else begin
            n = 0;
        end
    endfunction

    // Model state per instance: 0 = 1024-word memory, 1 = 4-word memory.
    int        maxp [2] = '{1023, 3};
    int        m_ptr [2], m_cnt [2], e_addr [2];
    bit        m_full [2], m_hp [2], e_we [2], e_err [2];
    bit [31:0] m_pend [2], e_data [2];

    task automatic put(input int i, input bit [31:0] w);
        e_we[i] = 1'b1;
        e_addr[i] = m_ptr[i];
        e_data[i] = w;
        m_cnt[i]++;
        if (m_ptr[i] == maxp[i]) m_full[i] = 1'b1;
        else m_ptr[i]++;
    endtask

    always @(posedge clk) begin
        int n;
        bit [31:0] w0, w1;
        encode(int'(in_kind), in_rs, in_rt, in_rd, in_shamt, in_imm, n, w0, w1);
        for (int i = 0; i < 2; i++) begin
            e_we[i] = 1'b0;
            e_err[i] = 1'b0;
            if (rst) begin
                m_ptr[i] = 0; m_cnt[i] = 0; m_full[i] = 1'b0; m_hp[i] = 1'b0;
            end else if (base_load) begin
                m_ptr[i] = int'(base_addr) % (maxp[i] + 1);
                m_cnt[i] = 0; m_full[i] = 1'b0; m_hp[i] = 1'b0;
            end else if (m_hp[i]) begin
                m_hp[i] = 1'b0;
                put(i, m_pend[i]);
            end else if (in_valid && !m_full[i]) begin
                if (n == 0 || (n == 2 && m_ptr[i] == maxp[i])) begin
                    e_err[i] = 1'b1;
                end else begin
                    put(i, w0);
                    if (n == 2) begin
                        m_hp[i] = 1'b1;
                        m_pend[i] = w1;
                    end
                end
            end
        end
    end

    logic        d_rdy [2], d_we [2], d_full [2], d_err [2];
    logic [31:0] d_addr [2], d_data [2], d_cnt [2];
    assign d_rdy[0] = rdy0;  assign d_rdy[1] = rdy1;
    assign d_we[0] = we0;    assign d_we[1] = we1;
    assign d_full[0] = full0; assign d_full[1] = full1;
    assign d_err[0] = err0;  assign d_err[1] = err1;
    assign d_addr[0] = 32'(addr0); assign d_addr[1] = 32'(addr1);
    assign d_data[0] = data0; assign d_data[1] = data1;
    assign d_cnt[0] = 32'(cnt0); assign d_cnt[1] = 32'(cnt1);

    always @(negedge clk) begin
        #2;
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready%0d", i), 32'(d_rdy[i]),
                    32'(!rst && !base_load && !m_full[i] && !m_hp[i]));
                chk($sformatf("im_we%0d", i), 32'(d_we[i]), 32'(e_we[i]));
                chk($sformatf("err%0d", i), 32'(d_err[i]), 32'(e_err[i]));
                chk($sformatf("full%0d", i), 32'(d_full[i]), 32'(m_full[i]));
                chk($sformatf("wr_count%0d", i), d_cnt[i], 32'(m_cnt[i]));
                if (e_we[i]) begin
                    chk($sformatf("im_addr%0d", i), d_addr[i], 32'(e_addr[i]));
                    chk($sformatf("im_wdata%0d", i), d_data[i], e_data[i]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input int k, input int rs, input int rt, input int rd, input int sh,
                       input logic [31:0] imm);
        in_valid = 1'b1;
        in_kind = 6'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
        in_imm = imm;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; base_load = 1'b0; base_addr = '0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
        @(posedge clk);
        check_en = 1'b1;
        repeat (2) tick();
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_we", 32'(we0), 0);
        chk("rst_addr", 32'(addr0), 0);
        chk("rst_wdata", data0, 0);
        chk("rst_full", 32'(full0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_count", 32'(cnt0), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(rdy0), 1);

        req(0, 1, 2, 3, 0, 0); tick();
        chk("addu_we", 32'(we0), 1);
        chk("addu_addr", 32'(addr0), 0);
        chk("addu_word", data0, 32'h0022_1821);
        chk("addu_count", 32'(cnt0), 1);
        req(11, 7, 2, 4, 3, 0); tick();
        chk("sll_word", data0, 32'h0002_20C0);
        chk("sll_addr", 32'(addr0), 1);
        req(28, 5, 0, 0, 0, 32'h0000_FFFE); tick();
        chk("bltz_word", data0, 32'h04A0_FFFE);
        chk("bltz_addr", 32'(addr0), 2);
        req(25, 5, 0, 0, 0, 32'h0000_FFFE); tick();
        chk("bgez_word", data0, 32'h04A1_FFFE);
        chk("bgez_addr", 32'(addr0), 3);
        chk("small_full", 32'(full1), 1);
        chk("small_ready", 32'(rdy1), 0);
        req(34, 0, 0, 0, 0, 32'h0010_0040); tick();
        chk("j_word", data0, 32'h0810_0040);
        chk("j_addr", 32'(addr0), 4);
        chk("small_no_write", 32'(we1), 0);

        in_valid = 1'b0; base_load = 1'b1; base_addr = 10'd1; tick();
        base_load = 1'b0;
        chk("small_unfull", 32'(full1), 0);
        chk("small_count0", 32'(cnt1), 0);
        req(0, 1, 2, 3, 0, 0); tick();
        chk("small_rebase_we", 32'(we1), 1);
        chk("small_rebase_addr", 32'(addr1), 1);
        in_valid = 1'b0; base_load = 1'b1; base_addr = 10'd3; tick();
        base_load = 1'b0;
`ifdef ENC_PSEUDO_EN
        req(36, 0, 8, 0, 0, 32'h1234_5678); tick();
        in_valid = 1'b0;
        chk("li_lui", data0, 32'h3C08_1234);
        chk("li_lui_addr", 32'(addr0), 3);
        chk("li_ready_low", 32'(rdy0), 0);
        chk("li_oneword_err", 32'(err1), 1);
        chk("li_oneword_nowr", 32'(we1), 0);
        tick();
        chk("li_ori", data0, 32'h3508_5678);
        chk("li_ori_addr", 32'(addr0), 4);
        chk("li_ready_back", 32'(rdy0), 1);
`else
        req(36, 0, 8, 0, 0, 32'h1234_5678); tick();
        in_valid = 1'b0;
        chk("li_off_err", 32'(err0), 1);
        chk("li_off_nowr", 32'(we0), 0);
        tick();
        chk("li_off_count", 32'(cnt0), 0);
`endif
        req(40, 1, 2, 3, 4, 0); tick();
        in_valid = 1'b0;
        chk("bad_kind_err", 32'(err0), 1);
        chk("bad_kind_nowr", 32'(we0), 0);
        tick();
        chk("err_one_cycle", 32'(err0), 0);

        repeat (4000) begin
            rst = ($urandom % 150) == 0;
            base_load = ($urandom % 20) == 0;
            base_addr = ($urandom % 2) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
            in_valid = ($urandom % 4) != 0;
            in_kind = (($urandom % 8) == 0) ? 6'd36 : 6'($urandom_range(0, 39));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_imm = $urandom;
            tick();
        end
        rst = 1'b0; base_load = 1'b0; in_valid = 1'b0;
        repeat (3) tick();
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
